mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have no parameters; all data and address paths SHALL be fixed at 32 bits.
REQ-002 The ports SHALL be, one per line: name  direction  width  meaning (clock and reset first):
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_res  in  32  effective byte address from EX/MEM.
- store_data  in  32  store source register value.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
- sign_ext  in  1  1 = sign-extend sub-word loads, 0 = zero-extend.
- mem_ack  in  1  memory completion strobe, one cycle.
- mem_rdata  in  32  memory read word, valid with mem_ack.
- stall  out  1  freeze upstream stages and bubble MEM/WB.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = write request.
- mem_addr  out  32  word address (alu_res with bits [1:0] forced to 0).
- mem_be  out  4  byte-lane enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_read  out  32  aligned, extended load result to MEM/WB mem_read input.
- misalign  out  1  misaligned access flag (see Configuration).

Function
REQ-003 FSM states SHALL be IDLE, WAIT, DONE, with IDLE as the reset state.
REQ-004 IDLE with MemRead or MemWrite high: stall=1 combinationally; next edge -> WAIT, registering mem_req=1, mem_we, mem_addr, mem_be and mem_wdata.
REQ-005 MemRead and MemWrite both high SHALL be executed as a load; the write SHALL be ignored.
REQ-006 WAIT: stall=1 and mem_req=1; request outputs SHALL be stable; on an edge with mem_ack=1 -> DONE, mem_req<=0, and for loads mem_read<=extracted mem_rdata.
REQ-007 DONE: stall=0 for exactly one cycle, no request issued; next edge -> IDLE.
REQ-008 Minimum access latency SHALL be 3 cycles of stall-free-to-stall-free (IDLE, WAIT with ack, DONE); each extra WAIT cycle adds one.
REQ-009 mem_ack in IDLE or DONE SHALL be ignored.
REQ-010 Byte enables: byte -> 4'b0001 << alu_res[1:0]; halfword -> 4'b0011 (alu_res[1]=0) or 4'b1100; word -> 4'b1111.
REQ-011 mem_wdata: byte -> store_data[7:0] in all four lanes; halfword -> store_data[15:0] in both halves; word -> store_data.
REQ-012 Load extraction SHALL select the lane per REQ-010 and sign- or zero-extend per sign_ext to 32 bits.
REQ-013 mem_read SHALL change only on a load completion; stores and non-memory cycles SHALL hold it.
REQ-014 IDLE with no access: stall=0, mem_req=0, FSM stays IDLE.

Reset
REQ-015 rst_n=0 SHALL immediately force state IDLE and stall, mem_req, mem_we, misalign, mem_addr, mem_be, mem_wdata, mem_read to 0, including mid-WAIT; a pending ack SHALL be discarded.
REQ-016 After rst_n rises, the first edge SHALL behave per REQ-004/REQ-014.

Configuration
REQ-017 With MISALIGN_CHECK_EN defined: halfword with alu_res[0]=1, or word with alu_res[1:0]!=0, in IDLE SHALL assert misalign=1 combinationally, keep stall=0, issue no request, and leave mem_read unchanged.
REQ-018 Without MISALIGN_CHECK_EN: misalign SHALL be tied 0; halfword uses alu_res[1] only, word ignores alu_res[1:0].

Verification
REQ-019 Word load alu_res=0x100, ack after 2 WAIT cycles, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=1111, stall high 3 cycles, mem_read=0xDEADBEEF.
REQ-020 Byte load alu_res=0x103, sign_ext=1, mem_rdata=0x80112233 -> mem_be=1000, mem_read=0xFFFFFF80; with sign_ext=0 -> 0x00000080.
REQ-021 Halfword store alu_res=0x202, store_data=0x1234ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_read unchanged.
REQ-022 rst_n pulsed low during WAIT -> mem_req and stall drop in same cycle; later mem_ack ignored; FSM IDLE.
REQ-023 MISALIGN_CHECK_EN, word load alu_res=0x101 -> misalign=1, mem_req=0, stall=0; without macro -> mem_addr=0x100, normal load.

Source files
------------

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   MEM-stage bridge between the pipeline and a single-outstanding memory
//   port with a one-cycle completion strobe. Each load/store runs through
//   IDLE -> WAIT -> DONE. Upstream is stalled until the memory acks, then
//   released for exactly one cycle in DONE.
//
//   Optional build macro: MISALIGN_CHECK_EN
//     defined   : misaligned halfword/word accesses raise misalign in IDLE
//                 and are dropped (no request, no stall, mem_read held).
//     undefined : misalign is tied low; halfwords use alu_res[1] only and
//                 words ignore alu_res[1:0].
//
// Ports
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   alu_res       effective byte address
//   store_data    store source value
//   MemRead       load request (wins when MemWrite is also high)
//   MemWrite      store request
//   size          00 byte, 01 halfword, 10/11 word
//   sign_ext      sign-extend (1) or zero-extend (0) sub-word loads
//   mem_ack       one-cycle completion strobe from memory
//   mem_rdata     memory read word, valid with mem_ack
//   stall         freeze upstream / bubble MEM-WB
//   mem_req       memory request, held until ack
//   mem_we        write request
//   mem_addr      word-aligned address
//   mem_be        byte-lane enables
//   mem_wdata     lane-replicated store data
//   mem_read      aligned, extended load result
//   misalign      misaligned access flag
// ---------------------------------------------------------------------------
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu_res,
    input  logic [31:0] store_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_read,
    output logic        misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic        access;
    logic        misalign_det;
    logic        accept;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;

    // Load context captured at accept time, used when the ack arrives.
    logic        ld_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        sext_q;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    assign access = MemRead | MemWrite;

`ifdef MISALIGN_CHECK_EN
    always_comb begin
        misalign_det = 1'b0;
        if (access) begin
            if (size == 2'b01)
                misalign_det = alu_res[0];
            else if (size[1])
                misalign_det = (alu_res[1:0] != 2'b00);
        end
    end
`else
    assign misalign_det = 1'b0;
`endif

    assign accept = access & ~misalign_det;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (mem_ack) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // stall and misalign depend on live inputs in IDLE; gating with rst_n
    // keeps them low while reset is held regardless of the request lines.
    always_comb begin
        stall    = 1'b0;
        mem_req  = 1'b0;
        misalign = 1'b0;
        case (state)
            IDLE: begin
                stall    = rst_n & accept;
                misalign = rst_n & misalign_det;
            end
            WAIT: begin
                stall   = 1'b1;
                mem_req = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- request formatting ----------------
    always_comb begin
        case (size)
            2'b00:   be_nxt = 4'b0001 << alu_res[1:0];
            2'b01:   be_nxt = alu_res[1] ? 4'b1100 : 4'b0011;
            default: be_nxt = 4'b1111;
        endcase
    end

    always_comb begin
        case (size)
            2'b00:   wdata_nxt = {4{store_data[7:0]}};
            2'b01:   wdata_nxt = {2{store_data[15:0]}};
            default: wdata_nxt = store_data;
        endcase
    end

    // ---------------- load extraction ----------------
    always_comb begin
        case (off_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   load_val = {{24{sext_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{sext_q & half_sel[15]}}, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            mem_read  <= '0;
            ld_q      <= 1'b0;
            size_q    <= '0;
            off_q     <= '0;
            sext_q    <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                mem_we    <= MemWrite & ~MemRead;
                mem_addr  <= {alu_res[31:2], 2'b00};
                mem_be    <= be_nxt;
                mem_wdata <= wdata_nxt;
                ld_q      <= MemRead;
                size_q    <= size;
                off_q     <= alu_res[1:0];
                sext_q    <= sign_ext;
            end
            if (state == WAIT && mem_ack && ld_q)
                mem_read <= load_val;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  size;
    logic        sign_ext;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_read;
    logic        misalign;

    mem_access_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_res    (alu_res),
        .store_data (store_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .size       (size),
        .sign_ext   (sign_ext),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        chk_wdata;
        logic [31:0] rd;
        int unsigned stalls;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: tracks one transaction from first stall cycle to the DONE cycle.
    initial begin
        bit          in_txn = 0;
        int unsigned stall_cnt = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_txn = 0;
                q.delete();
            end else begin
                if (!in_txn && stall) begin
                    in_txn    = 1;
                    stall_cnt = 0;
                end
                if (in_txn) begin
                    if (stall) stall_cnt++;
                    if (mem_req) begin
                        if (q.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
                        else begin
                            e = q[0];
                            chk("mem_addr", mem_addr, e.addr);
                            chk("mem_be", {28'd0, mem_be}, {28'd0, e.be});
                            chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                            if (e.chk_wdata) chk("mem_wdata", mem_wdata, e.wdata);
                            chk("misalign_req", {31'd0, misalign}, 32'd0);
                        end
                    end
                    if (!stall) begin
                        if (q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
                        else begin
                            e = q.pop_front();
                            chk("mem_read", mem_read, e.rd);
                            chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
                            chk("req_in_done", {31'd0, mem_req}, 32'd0);
                        end
                        in_txn = 0;
                    end
                end
            end
        end
    end

    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic sx, input logic [31:0] a, input logic [31:0] sd,
                             input logic [31:0] rdat, input int unsigned waits,
                             input logic [31:0] e_addr, input logic [3:0] e_be,
                             input logic e_we, input logic [31:0] e_wd,
                             input logic [31:0] e_rd);
        exp_t e;
        int   n;
        e.addr = e_addr; e.be = e_be; e.we = e_we; e.wdata = e_wd;
        e.chk_wdata = e_we; e.rd = e_rd; e.stalls = 1 + waits;
        q.push_back(e);
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; size = sz; sign_ext = sx;
        alu_res = a; store_data = sd;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!mem_req && n < 8);
        if (!mem_req) begin
            chk("req_timeout", 32'd0, 32'd1);
            MemRead = 0; MemWrite = 0;
            q.delete();
        end else begin
            repeat (waits - 1) begin
                @(posedge clk); #1;
            end
            mem_ack = 1; mem_rdata = rdat;
            @(posedge clk); #1;
            mem_ack = 0; mem_rdata = 32'h5A5A_5A5A;
            @(posedge clk); #1;
            MemRead = 0; MemWrite = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] last_rd;
        rst_n = 0; MemRead = 1; MemWrite = 0; size = 2'b10; sign_ext = 0;
        alu_res = 32'h104; store_data = 32'h0; mem_ack = 0; mem_rdata = 32'h0;
        #3;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_read", mem_read, 32'd0);
        MemRead = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        chk("idle_stall", {31'd0, stall}, 32'd0);

        //        rd wr sz    sx addr          sdata         rdata      w  e_addr   be       we e_wdata        e_read
        do_access(1, 0, 2'd2, 0, 32'h100, 32'h0,        32'hDEADBEEF, 2, 32'h100, 4'b1111, 0, 32'h0,        32'hDEADBEEF);
        do_access(1, 0, 2'd0, 1, 32'h103, 32'h0,        32'h80112233, 1, 32'h100, 4'b1000, 0, 32'h0,        32'hFFFFFF80);
        do_access(1, 0, 2'd0, 0, 32'h103, 32'h0,        32'h80112233, 1, 32'h100, 4'b1000, 0, 32'h0,        32'h00000080);
        do_access(0, 1, 2'd1, 0, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 1, 32'h200, 4'b1100, 1, 32'hABCDABCD, 32'h00000080);
        do_access(0, 1, 2'd0, 0, 32'h201, 32'h000000A5, 32'hFFFFFFFF, 3, 32'h200, 4'b0010, 1, 32'hA5A5A5A5, 32'h00000080);
        do_access(1, 0, 2'd1, 1, 32'h206, 32'h0,        32'h80017FFF, 1, 32'h204, 4'b1100, 0, 32'h0,        32'hFFFF8001);
        do_access(1, 0, 2'd1, 1, 32'h204, 32'h0,        32'h80017FFF, 1, 32'h204, 4'b0011, 0, 32'h0,        32'h00007FFF);
        do_access(1, 1, 2'd2, 0, 32'h300, 32'h00000055, 32'h01234567, 1, 32'h300, 4'b1111, 0, 32'h0,        32'h01234567);
        do_access(1, 0, 2'd3, 0, 32'h010, 32'h0,        32'hCAFEF00D, 1, 32'h010, 4'b1111, 0, 32'h0,        32'hCAFEF00D);
        do_access(1, 0, 2'd0, 0, 32'h101, 32'h0,        32'h11223344, 1, 32'h100, 4'b0010, 0, 32'h0,        32'h00000033);
        do_access(0, 1, 2'd2, 0, 32'h400, 32'h0BADF00D, 32'hFFFFFFFF, 2, 32'h400, 4'b1111, 1, 32'h0BADF00D, 32'h00000033);
`ifdef MISALIGN_CHECK_EN
        last_rd = 32'h00000033;
        @(posedge clk); #1;
        MemRead = 1; size = 2'd2; alu_res = 32'h101;
        #1;
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("mis_req", {31'd0, mem_req}, 32'd0);
        chk("mis_read", mem_read, last_rd);
        size = 2'd1; alu_res = 32'h203;
        #1;
        chk("mis_half", {31'd0, misalign}, 32'd1);
        MemRead = 0;
        #1;
        chk("mis_clear", {31'd0, misalign}, 32'd0);
`else
        do_access(1, 0, 2'd2, 0, 32'h101, 32'h0,        32'h89ABCDEF, 1, 32'h100, 4'b1111, 0, 32'h0,        32'h89ABCDEF);
        last_rd = 32'h89ABCDEF;
`endif

        // Ack while idle must be ignored.
        @(posedge clk); #1;
        mem_ack = 1; mem_rdata = 32'hFFFF0000;
        @(posedge clk); #1;
        mem_ack = 0;
        chk("idle_ack_req", {31'd0, mem_req}, 32'd0);
        chk("idle_ack_stall", {31'd0, stall}, 32'd0);
        chk("idle_ack_read", mem_read, last_rd);

        // Reset pulsed mid-WAIT.
        begin
            exp_t e;
            e.addr = 32'h500; e.be = 4'b1111; e.we = 0; e.wdata = 0;
            e.chk_wdata = 0; e.rd = 0; e.stalls = 3;
            q.push_back(e);
        end
        @(posedge clk); #1;
        MemRead = 1; size = 2'd2; alu_res = 32'h500;
        @(posedge clk); #1;
        chk("wait_req", {31'd0, mem_req}, 32'd1);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("midrst_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_addr", mem_addr, 32'd0);
        chk("midrst_read", mem_read, 32'd0);
        @(posedge clk); #1;
        MemRead = 0; rst_n = 1;
        mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_ack = 0;
        chk("postrst_req", {31'd0, mem_req}, 32'd0);
        chk("postrst_stall", {31'd0, stall}, 32'd0);
        chk("postrst_read", mem_read, 32'd0);

        do_access(0, 1, 2'd2, 0, 32'h600, 32'h13579BDF, 32'hFFFFFFFF, 1, 32'h600, 4'b1111, 1, 32'h13579BDF, 32'h00000000);
        do_access(1, 0, 2'd0, 1, 32'h602, 32'h0,        32'h00FF0000, 1, 32'h600, 4'b0100, 0, 32'h0,        32'hFFFFFFFF);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
